// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter that hands one shared AXI write path (AW/W/B) to one of two
// requesters for a whole transaction, generating wlast from the granted awlen.
module axi_wr_arbiter #(
    parameter int AW = 32,
    parameter int DW = 64,
    parameter int SW = 8
) (
    input  logic            axi_aclk,
    input  logic            rst,
    input  logic [1:0]      m_awvalid,
    input  logic [2*AW-1:0] m_awaddr,
    input  logic [15:0]     m_awlen,
    input  logic [5:0]      m_awsize,
    input  logic [3:0]      m_awburst,
    output logic [1:0]      m_awready,
    input  logic [1:0]      m_wvalid,
    input  logic [2*DW-1:0] m_wdata,
    input  logic [2*SW-1:0] m_wstrb,
    output logic [1:0]      m_wready,
    output logic [1:0]      m_bvalid,
    output logic [1:0]      m_bresp,
    input  logic [1:0]      m_bready,
    output logic [AW-1:0]   axi_awaddr,
    output logic [7:0]      axi_awlen,
    output logic [2:0]      axi_awsize,
    output logic [1:0]      axi_awburst,
    output logic            axi_awvalid,
    input  logic            axi_awready,
    output logic [DW-1:0]   axi_wdata,
    output logic [SW-1:0]   axi_wstrb,
    output logic            axi_wlast,
    output logic            axi_wvalid,
    input  logic            axi_wready,
    input  logic [1:0]      axi_bresp,
    input  logic            axi_bvalid,
    output logic            axi_bready,
    output logic            grant,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic            r_grant;
    logic            r_lastGrant;
    logic [7:0]      r_beatCnt;
    logic            r_awvalid;
    logic [AW-1:0]   r_awaddr;
    logic [7:0]      r_awlen;
    logic [2:0]      r_awsize;
    logic [1:0]      r_awburst;

    logic            w_winner;
    logic            w_grantWvalid;
    logic            w_grantBready;
    logic [DW-1:0]   w_grantWdata;
    logic [SW-1:0]   w_grantWstrb;
    logic            w_wBeat;
    logic            w_bHandshake;

    // On a tie the requester that did not win last time gets the bus.
    assign w_winner      = (m_awvalid == 2'b11) ? ~r_lastGrant : m_awvalid[1];
    assign w_grantWvalid = r_grant ? m_wvalid[1] : m_wvalid[0];
    assign w_grantBready = r_grant ? m_bready[1] : m_bready[0];
    assign w_grantWdata  = r_grant ? m_wdata[DW +: DW] : m_wdata[0 +: DW];
    assign w_grantWstrb  = r_grant ? m_wstrb[SW +: SW] : m_wstrb[0 +: SW];
    assign w_wBeat       = (r_state == DATA) && w_grantWvalid && axi_wready;
    assign w_bHandshake  = (r_state == RESP) && axi_bvalid && w_grantBready;

    always_ff @(posedge axi_aclk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        m_awready   = 2'b00;
        m_wready    = 2'b00;
        m_bvalid    = 2'b00;
        m_bresp     = 2'b00;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_wlast   = 1'b0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        case (r_state)
            IDLE: begin
                if (|m_awvalid) w_nextState = ADDR;
            end
            ADDR: begin
                m_awready = r_grant ? {axi_awready, 1'b0} : {1'b0, axi_awready};
                if (axi_awready) w_nextState = DATA;
            end
            DATA: begin
                axi_wvalid = w_grantWvalid;
                axi_wdata  = w_grantWdata;
                axi_wstrb  = w_grantWstrb;
                axi_wlast  = (r_beatCnt == 8'd0);
                m_wready   = r_grant ? {axi_wready, 1'b0} : {1'b0, axi_wready};
                if (w_wBeat && (r_beatCnt == 8'd0)) w_nextState = RESP;
            end
            RESP: begin
                m_bvalid   = r_grant ? {axi_bvalid, 1'b0} : {1'b0, axi_bvalid};
                m_bresp    = axi_bresp;
                axi_bready = w_grantBready;
                if (w_bHandshake) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // beat_cnt counts remaining beats after the current one, so wlast is simply cnt==0.
    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            r_grant     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_beatCnt   <= 8'd0;
            r_awvalid   <= 1'b0;
            r_awaddr    <= '0;
            r_awlen     <= 8'd0;
            r_awsize    <= 3'd0;
            r_awburst   <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|m_awvalid) begin
                        r_awvalid <= 1'b1;
                        r_grant   <= w_winner;
                        r_awaddr  <= w_winner ? m_awaddr[AW +: AW] : m_awaddr[0 +: AW];
                        r_awlen   <= w_winner ? m_awlen[15:8]      : m_awlen[7:0];
                        r_awsize  <= w_winner ? m_awsize[5:3]      : m_awsize[2:0];
                        r_awburst <= w_winner ? m_awburst[3:2]     : m_awburst[1:0];
                    end
                end
                ADDR: begin
                    if (axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_beatCnt <= r_awlen;
                    end
                end
                DATA: begin
                    if (w_wBeat && (r_beatCnt != 8'd0)) r_beatCnt <= r_beatCnt - 8'd1;
                end
                RESP: begin
                    if (w_bHandshake) r_lastGrant <= r_grant;
                end
                default: ;
            endcase
        end
    end

    assign axi_awvalid = r_awvalid;
    assign axi_awaddr  = r_awaddr;
    assign axi_awlen   = r_awlen;
    assign axi_awsize  = r_awsize;
    assign axi_awburst = r_awburst;
    assign grant       = r_grant;
    assign busy        = (r_state != IDLE);

endmodule
